// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: opcodes, FSM encoding, instruction fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction word layout
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RSA_HI = 8;
    localparam int RSA_LO = 6;
    localparam int RSB_HI = 5;
    localparam int RSB_LO = 3;
    localparam int IMM9_W = 9;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Opcodes that produce a register file write
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

    // Opcodes 7..14 have no meaning; they run as NOP and flag illegal
    function automatic logic op_undefined(input logic [3:0] op);
        return (op > OP_LDI) && (op < OP_HALT);
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction fetch and register file port bundle between the sequencer and its neighbours.
// Latency: n/a (wires only).
// Backpressure: fetch holds imem_req until imem_valid; register file ports have none.
interface core_ctrl_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;
    logic [2:0]      rf_ra;
    logic [2:0]      rf_rb;
    logic [15:0]     rf_rd_a;
    logic [15:0]     rf_rd_b;
    logic [2:0]      rf_wa;
    logic [15:0]     rf_wd;
    logic            rf_we;

    modport master (
        output imem_req, imem_addr, rf_ra, rf_rb, rf_wa, rf_wd, rf_we,
        input  imem_valid, imem_data, rf_rd_a, rf_rd_b
    );

    modport slave (
        input  imem_req, imem_addr, rf_ra, rf_rb, rf_wa, rf_wd, rf_we,
        output imem_valid, imem_data, rf_rd_a, rf_rd_b
    );
endinterface

// File: rtl/core_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR on two operands, LDI sign-extends imm9.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module core_alu
    import core_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    input  logic [IMM9_W-1:0] imm,
    output logic [15:0]       result
);

    // Select the operation; non-writing opcodes produce zero
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = {{(16-IMM9_W){imm[IMM9_W-1]}}, imm};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Fetch/decode/execute/writeback sequencer driving an 8x16 register file; RETIRE_CNT_EN adds retire_cnt.
// Latency: 4 cycles per writing instruction (3 for NOP/undefined) with zero-wait fetch.
// Backpressure: stalls in FETCH with imem_req held until imem_valid; HALT stops fetching until rst.
module core_ctrl
    import core_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    core_ctrl_if.master bus,
    output logic        halted,
    output logic        illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic [15:0]     res_q;
    logic [15:0]     alu_res;
    logic            illegal_q;
    logic [3:0]      op;

    assign op = ir_q[OP_HI:OP_LO];

    core_alu u_alu (
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .imm    (ir_q[IMM9_W-1:0]),
        .result (alu_res)
    );

    // Next-state decode; NOP/undefined skip the writeback cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.imem_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)     state_d = S_HALT;
                else if (op_writes(op)) state_d = S_WB;
                else                    state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs come from registered state only; rst masks request and write strobe in its own cycle
    always_comb begin
        bus.imem_req  = (state_q == S_FETCH) && !rst;
        bus.imem_addr = pc_q;
        bus.rf_ra     = ir_q[RSA_HI:RSA_LO];
        bus.rf_rb     = ir_q[RSB_HI:RSB_LO];
        bus.rf_wa     = ir_q[RD_HI:RD_LO];
        bus.rf_wd     = res_q;
        bus.rf_we     = (state_q == S_WB) && !rst;
        halted        = (state_q == S_HALT);
        illegal       = illegal_q;
    end

    // State register plus per-stage datapath captures
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir_q <= bus.imem_data;
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    a_q <= bus.rf_rd_a;
                    b_q <= bus.rf_rd_b;
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    if (op_undefined(op)) illegal_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_q;

    // One count per instruction as it leaves EXEC or WB toward FETCH or HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (((state_q == S_EXEC) && (state_d != S_WB)) || (state_q == S_WB)) begin
            retire_q <= retire_q + 16'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
`timescale 1ns/1ps
module tb_core_ctrl;
    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    logic illegal;
`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    core_ctrl_if #(.PC_W(PC_W)) bus();

    core_ctrl #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .halted     (halted),
`ifdef RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Register file environment: combinational reads, write on rising edge
    logic [15:0] rf_mem [8];
    assign bus.rf_rd_a = rf_mem[bus.rf_ra];
    assign bus.rf_rd_b = rf_mem[bus.rf_rb];
    always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;

    // Reference model state
    int model_rf [8];
    int model_pc;
    int model_illegal;
    int model_retire;
    int checks;
    int passed;
    int failed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
        logic [3:0] o; logic [2:0] d; logic [2:0] x; logic [2:0] y;
        o = op[3:0]; d = rd[2:0]; x = ra[2:0]; y = rb[2:0];
        return {o, d, x, y, 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input int rd, input int imm);
        logic [2:0] d; logic [8:0] i;
        d = rd[2:0]; i = imm[8:0];
        return {4'd6, d, i};
    endfunction

    // Behavioural result of one instruction, modulo 2^16
    function automatic int ref_result(input int op, input int a, input int b, input int imm9);
        case (op)
            1: return (a + b) % 65536;
            2: return (a - b + 65536) % 65536;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return (imm9 >= 256) ? (imm9 - 512 + 65536) : imm9;
            default: return 0;
        endcase
    endfunction

    // Called at a falling edge with the core in FETCH; returns at the falling edge of the next FETCH/HALT
    task automatic run_instr(input logic [15:0] instr, input int waits);
        int op, rd, ra, rb, imm, n, nwe, exp_res, writes, exp_n;
        logic [2:0]  got_wa;
        logic [15:0] got_wd;
        bit done;
        op  = int'(instr) / 4096;
        rd  = (int'(instr) / 512) % 8;
        ra  = (int'(instr) / 64) % 8;
        rb  = (int'(instr) / 8) % 8;
        imm = int'(instr) % 512;
        writes  = (op >= 1 && op <= 6) ? 1 : 0;
        exp_res = ref_result(op, model_rf[ra], model_rf[rb], imm);
        exp_n   = writes ? 4 : 3;

        chk("fetch_req", {31'd0, bus.imem_req}, 1);
        chk("fetch_addr", {24'd0, bus.imem_addr}, model_pc);
        for (int w = 0; w < waits; w++) begin
            bus.imem_valid = 1'b0;
            bus.imem_data  = 16'($urandom);
            @(negedge clk);
            chk("stall_req", {31'd0, bus.imem_req}, 1);
            chk("stall_addr", {24'd0, bus.imem_addr}, model_pc);
            chk("stall_we", {31'd0, bus.rf_we}, 0);
        end
        bus.imem_valid = 1'b1;
        bus.imem_data  = instr;
        n = 0; nwe = 0; done = 1'b0; got_wa = '0; got_wd = '0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (bus.rf_we) begin
                nwe++;
                got_wa = bus.rf_wa;
                got_wd = bus.rf_wd;
            end
            if (bus.imem_req || halted || n >= 12) done = 1'b1;
            else begin
                // Junk on the fetch port while no request is outstanding must be ignored
                bus.imem_valid = 1'($urandom % 2);
                bus.imem_data  = 16'($urandom);
            end
        end
        bus.imem_valid = 1'b0;

        chk("cycles", n, exp_n);
        chk("we_count", nwe, writes);
        if (writes != 0) begin
            chk("wb_addr", {29'd0, got_wa}, rd);
            chk("wb_data", {16'd0, got_wd}, exp_res);
            model_rf[rd] = exp_res;
        end
        model_pc = (model_pc + 1) % (1 << PC_W);
        if (op >= 7 && op <= 14) model_illegal = 1;
        model_retire++;
        chk("illegal", {31'd0, illegal}, model_illegal);
        chk("halted", {31'd0, halted}, (op == 15) ? 1 : 0);
`ifdef RETIRE_CNT_EN
        chk("retire", {16'd0, retire_cnt}, model_retire % 65536);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, bus.imem_req}, 0);
        chk({tag, "_we"}, {31'd0, bus.rf_we}, 0);
        chk({tag, "_wa"}, {29'd0, bus.rf_wa}, 0);
        chk({tag, "_wd"}, {16'd0, bus.rf_wd}, 0);
        chk({tag, "_ra"}, {29'd0, bus.rf_ra}, 0);
        chk({tag, "_rb"}, {29'd0, bus.rf_rb}, 0);
        chk({tag, "_halted"}, {31'd0, halted}, 0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 0);
`ifdef RETIRE_CNT_EN
        chk({tag, "_retire"}, {16'd0, retire_cnt}, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, op;
        logic [15:0] keep7;
        checks = 0; passed = 0; failed = 0;
        model_pc = 0; model_illegal = 0; model_retire = 0;
        for (int i = 0; i < 8; i++) model_rf[i] = 0;

        // Reset with a stray fetch response that must be ignored
        rst = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'h6FFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        bus.imem_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed program
        run_instr(enc_ldi(1, 5), 0);
        chk("ldi_r1", {16'd0, rf_mem[1]}, 32'h0005);
        run_instr(enc_ldi(2, 9'h1FD), 0);
        chk("ldi_r2", {16'd0, rf_mem[2]}, 32'hFFFD);
        run_instr(enc(1, 3, 1, 2), 0);
        chk("add_r3", {16'd0, rf_mem[3]}, 32'h0002);
        run_instr(enc(2, 4, 2, 1), 0);
        chk("sub_r4", {16'd0, rf_mem[4]}, 32'hFFF8);
        run_instr(enc(5, 5, 1, 1), 0);
        chk("xor_r5", {16'd0, rf_mem[5]}, 32'h0000);
        run_instr(enc_ldi(0, int'($urandom % 512)), 0);
        run_instr(enc_ldi(6, int'($urandom % 512)), 0);
        run_instr(enc_ldi(7, int'($urandom % 512)), 0);

        // Fetch stall of three cycles
        run_instr(enc(1, 6, 3, 4), 3);

        // Undefined opcode
        run_instr(enc(9, 2, 1, 1), 0);
        chk("illegal_set", {31'd0, illegal}, 1);

        // Random traffic long enough to wrap the PC
        for (int k = 0; k < 260; k++) begin
            r = int'($urandom % 10);
            op = (r >= 7) ? (7 + int'($urandom % 8)) : r;
            run_instr(enc(op, int'($urandom % 8), int'($urandom % 8), int'($urandom % 8)),
                      int'($urandom % 3));
            if (model_pc == 0) chk("pc_wrap", {24'd0, bus.imem_addr}, 0);
        end
        chk("illegal_sticky", {31'd0, illegal}, 1);

        // HALT is terminal: fetch port pulses are ignored
        run_instr(enc(15, 0, 0, 0), 0);
        for (int k = 0; k < 12; k++) begin
            bus.imem_valid = 1'($urandom % 2);
            bus.imem_data  = enc_ldi(1, 1);
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 1);
            chk("halt_req", {31'd0, bus.imem_req}, 0);
            chk("halt_we", {31'd0, bus.rf_we}, 0);
        end
        bus.imem_valid = 1'b0;

        // Reset out of HALT
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst1");
        rst = 1'b0;
        model_pc = 0; model_illegal = 0; model_retire = 0;
        @(negedge clk);

        run_instr(enc_ldi(7, int'($urandom % 512)), 0);
        run_instr(enc(0, 0, 0, 0), 1);
        run_instr(enc(4, 6, 1, 7), 0);
`ifdef RETIRE_CNT_EN
        chk("retire3", {16'd0, retire_cnt}, 3);
`endif

        // Reset landing in the WB cycle must suppress the write
        keep7 = rf_mem[7];
        chk("wbrst_req", {31'd0, bus.imem_req}, 1);
        bus.imem_valid = 1'b1;
        bus.imem_data  = enc(1, 7, 1, 2);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wbrst_pre_we", {31'd0, bus.rf_we}, 1);
        rst = 1'b1;
        #1;
        chk("wbrst_we", {31'd0, bus.rf_we}, 0);
        @(negedge clk);
        check_reset_outputs("rst2");
        rst = 1'b0;
        @(negedge clk);
        chk("wbrst_r7", {16'd0, rf_mem[7]}, {16'd0, keep7});
        chk("wbrst_r7_model", {16'd0, rf_mem[7]}, model_rf[7]);
        chk("restart_req", {31'd0, bus.imem_req}, 1);
        chk("restart_addr", {24'd0, bus.imem_addr}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer sitting directly upstream of the 8x16-bit register file.
- Fetches 16-bit instructions over a valid handshake, decodes them, and drives the register file read ports (ra/rb) and write port (wa/wd/we).
- Computes results with an internal ALU and writes them back through the register file write port.

Parameters:
- PC_W, 8, program-counter and instruction-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until accepted.
- imem_addr  out  PC_W  fetch address (current PC).
- imem_valid  in  1  instruction data valid; accepted only while imem_req=1.
- imem_data  in  16  instruction word.
- rf_ra  out  3  register file read address A.
- rf_rb  out  3  register file read address B.
- rf_rd_a  in  16  register file read data A (combinational from rf_ra).
- rf_rd_b  in  16  register file read data B.
- rf_wa  out  3  register file write address.
- rf_wd  out  16  register file write data.
- rf_we  out  1  register file write enable; single-cycle pulse.
- halted  out  1  core stopped.
- illegal  out  1  sticky flag: an undefined opcode was executed.

Behaviour:
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs_a, [5:3] rs_b, [2:0] ignored. LDI uses [8:0] as imm9, sign-extended to 16 bits.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (A-B)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI
  - 15 HALT
  - 7-14 undefined: executed as NOP and set illegal.
- Arithmetic is modulo 2^16; carry/borrow discarded.
- FSM states: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT is terminal.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Stay in FETCH while imem_valid=0.
  - On imem_valid=1: latch IR from imem_data, PC <= PC+1 (wraps 2^PC_W-1 -> 0), go to DECODE.
- DECODE: rf_ra=IR rs_a, rf_rb=IR rs_b; latch rf_rd_a/rf_rd_b into operand registers A/B.
- EXEC: compute result into result register.
  - HALT -> go to HALT state.
  - NOP/undefined -> go to FETCH directly, with no WB cycle.
- WB: rf_we=1, rf_wa=IR rd, rf_wd=result, for exactly one cycle; then FETCH.
- Minimum of 4 cycles per writing instruction with zero-wait memory (3 cycles for NOP).
- HALT state: halted=1, imem_req=0, rf_we=0; only rst exits.
- imem_valid while imem_req=0 is ignored.
- A write to rd equal to a source register of the next instruction is safe: WB completes before the next DECODE.
- Reset values:
  - state=FETCH, PC=RESET_PC, IR=0, A=B=result=0.
  - imem_req=0 in the reset cycle, asserted from the first cycle after rst deasserts.
  - rf_we=0, rf_wa/rf_wd/rf_ra/rf_rb=0, halted=0, illegal=0.
- rst mid-operation (including mid-fetch or in WB): abandon the instruction and suppress rf_we in that cycle. A pending fetch is dropped; any imem_valid in the reset cycle is ignored.
- rf_* outputs are registered or decoded from registered state only; no combinational path from imem_data.

Optional Feature:
- Macro RETIRE_CNT_EN.
- When defined:
  - Adds output port retire_cnt [15:0].
  - Increments by 1 on each instruction leaving EXEC or WB toward FETCH or HALT (NOP, undefined and HALT all count).
  - Wraps at 0xFFFF -> 0; reset to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - FSM state encoding;
  - instruction field bit positions;
  - imm9 width.
- One natural sub-module: core_alu, purely combinational (op, a, b, imm -> result), instantiated in core_ctrl.

Test Plan:
- Reset, then imem returns LDI r1,#5 and LDI r2,#-3 (imm9=0x1FD) with zero wait -> WB cycles write r1=0x0005 and r2=0xFFFD; rf_we high exactly one cycle each; imem_addr 0,1.
- ADD r3,r1,r2 after the above -> rf_wa=3, rf_wd=0x0002; SUB r4,r2,r1 -> rf_wd=0xFFF8; XOR r5,r1,r1 -> 0x0000.
- imem_valid held low 3 cycles during FETCH -> imem_req stays high, imem_addr stable, no rf_we; instruction completes normally once imem_valid=1.
- Opcode 0x9 fetched -> illegal=1 and stays set, no rf_we, next fetch at PC+1; then HALT -> halted=1, imem_req=0 indefinitely, imem_valid pulses ignored.
- PC at 0xFF with PC_W=8 -> next imem_addr=0x00.
- rst asserted during the WB cycle -> rf_we=0 that cycle, all outputs at reset values next cycle, fetch restarts at RESET_PC. With RETIRE_CNT_EN defined: retire_cnt=3 after three completed instructions, 0 after rst.
